alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

- Registered issue stage that sits between instruction decode and the combinational ALU.
- Translates decoded MIPS opcode/funct fields into the ALU's 4-bit control code and selects and forwards operands.
- Holds the result in an EX-input pipeline register under a valid/ready handshake.
- Produces exactly the `alu_control`/`a`/`b` contract the ALU consumes, including shift amount carried in `b[10:6]`.

## Interface
Parameters:
- `DATA_W`, 32, operand width; only 32 is supported.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: decode presents an instruction.
- `in_ready` out 1: stage accepts this cycle.
- `opcode` in 6, `funct` in 6: instruction fields.
- `rs_addr`, `rt_addr`, `rd_addr` in 5 each: register specifiers.
- `rs_data`, `rt_data` in 32: register-file read data.
- `imm` in 16: `instr[15:0]`; contains shamt at `[10:6]`.
- `flush` in 1: discard stage contents.
- `exmem_we` in 1, `exmem_addr` in 5, `exmem_data` in 32: EX/MEM forward source.
- `memwb_we` in 1, `memwb_addr` in 5, `memwb_data` in 32: MEM/WB forward source.
- `out_valid` out 1, `out_ready` in 1: handshake to EX.
- `alu_a` out 32, `alu_b` out 32, `alu_control` out 4: ALU operands and opcode.
- `out_dest` out 5, `out_reg_write` out 1: writeback target and enable.
- `illegal` out 1: the held instruction is unsupported.

## Operation
- **Transfer:**
  - Accept on `in_valid && in_ready`.
  - Output transfer on `out_valid && out_ready`.
- **Forwarding:** applied to `rs_data`/`rt_data` at acceptance.
  - EX/MEM wins over MEM/WB.
  - A source matches only if its `we` is set and its addr is non-zero and equal to the specifier.
  - Register 0 is never forwarded.
  - Values are frozen once captured.
- **Sign extension:** sext = `{{16{imm[15]}},imm}`; zext = `{16'b0,imm}`.
- **R-type (`opcode` 0)**, `alu_a`=fwd rs, `alu_b`=fwd rt, `out_dest`=rd, `out_reg_write`=1:
  - `funct` 20/21 → 0010.
  - 22/23 → 0110.
  - 24 → 0000.
  - 25 → 0001.
  - 26 → 0100.
  - 27 → 1100.
  - 2A → 0111.
  - 18 → 0101.
  - 1A → 1011.
- **Shifts:** `funct` 00→1000, 02→1001, 03→1010.
  - `alu_a`=fwd rt, `alu_b`=zext (shamt in `[10:6]`), `out_dest`=rd.
- **I-type:**
  - 08/09 → 0010 sext.
  - 0A → 0111 sext.
  - 0C → 0000 zext.
  - 0D → 0001 zext.
  - 0E → 0100 zext.
  - For all of these: `alu_a`=fwd rs, `out_dest`=rt, `out_reg_write`=1.
- **Memory and branch:**
  - lw 23: 0010 sext, `out_dest`=rt, `out_reg_write`=1.
  - sw 2B: 0010 sext, `out_reg_write`=0.
  - beq 04: 0110, `alu_b`=fwd rt, `out_reg_write`=0.
- **Anything else:**
  - `alu_control`=0010, operands as R-type, `out_reg_write`=0.
  - `illegal`=1; the instruction still flows.
- **`out_dest` 0:** `out_reg_write` forced to 0.

## Timing
- **Reset** (registered, next edge):
  - `out_valid`=0, `alu_a`=0, `alu_b`=0, `alu_control`=0010, `out_dest`=0, `out_reg_write`=0, `illegal`=0.
  - Skid entry cleared.
  - `in_ready`=0 while `reset` is high.
- **Latency and throughput:** accepted at edge N → `out_valid`=1 with the data after edge N. Sustained throughput is 1 per cycle.
- **Stall:** while `out_valid && !out_ready`, all outputs hold stable.
- **Flush:**
  - Clears `out_valid` and the skid at the next edge.
  - An input presented the same cycle is dropped.
  - `reset` dominates `flush`.
- **Simultaneous transfer:** an output transfer and an input acceptance in the same cycle replace the entry with no bubble.
- **Reset mid-stall:** discards the held entry; no output transfer completes on that edge.

## Configuration
- **`ALU_ISSUE_SKID_EN` defined:**
  - Two-entry skid buffer.
  - `in_ready` = !skid_full, driven straight from a flop.
  - While the output is stalled, one extra instruction is absorbed into the skid and drains in order.
- **Undefined:**
  - Single entry.
  - `in_ready` = !`out_valid` || `out_ready` (combinational from `out_ready`).

## Test plan
- **Add:** add r3,r1,r2 with `rs_data`=5, `rt_data`=7 → next cycle `alu_control`=0010, `alu_a`=5, `alu_b`=7, `out_dest`=3, `out_reg_write`=1.
- **Immediates:**
  - addi with `imm`=FFFF → `alu_b`=FFFFFFFF.
  - ori with `imm`=FFFF → `alu_b`=0000FFFF, `alu_control`=0001.
- **Shift:** sra with shamt=4, `rt_data`=80000000 → `alu_a`=80000000, `alu_b[10:6]`=4, `alu_control`=1010.
- **Forwarding:** `exmem_addr`=`memwb_addr`=`rs_addr`=2, both `we`=1 → `alu_a`=`exmem_data`.
  - `rs_addr`=0 with a matching `exmem_addr`=0 → `alu_a`=`rs_data`.
- **Back-pressure:**
  - Hold `out_ready`=0 three cycles while issuing a stream → outputs are stable and no instruction is lost or duplicated.
  - With `ALU_ISSUE_SKID_EN`, exactly one extra instruction is accepted.
- **Flush and illegal:**
  - Flush with `out_valid`=1 → `out_valid`=0 next cycle.
  - Opcode 3F → `illegal`=1, `out_reg_write`=0, `alu_control`=0010.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Registered ALU issue stage: decodes MIPS opcode/funct into ALU control, forwards operands, holds an EX-input entry.
// Optional feature macro: ALU_ISSUE_SKID_EN (two-entry skid buffer with a registered in_ready).
module alu_issue_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  input  logic [4:0]        rd_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [15:0]       imm,
  input  logic              flush,
  input  logic              exmem_we,
  input  logic [4:0]        exmem_addr,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_we,
  input  logic [4:0]        memwb_addr,
  input  logic [DATA_W-1:0] memwb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_control,
  output logic [4:0]        out_dest,
  output logic              out_reg_write,
  output logic              illegal
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [3:0]        ctrl;
    logic [4:0]        dest;
    logic              wr;
    logic              ill;
  } entry_t;

  localparam entry_t RESET_ENTRY = '{a: '0, b: '0, ctrl: 4'b0010, dest: 5'd0, wr: 1'b0, ill: 1'b0};

  logic [4:0]        src_addr [2];
  logic [DATA_W-1:0] src_data [2];
  logic [DATA_W-1:0] fwd_data [2];
  logic [DATA_W-1:0] sext, zext;
  entry_t            dec_d;
  entry_t            out_q;
  logic              out_valid_q;
  logic              accept;

  assign src_addr[0] = rs_addr;
  assign src_addr[1] = rt_addr;
  assign src_data[0] = rs_data;
  assign src_data[1] = rt_data;

  // EX/MEM has priority over MEM/WB; register 0 never matches.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_data[gi] =
        (exmem_we && (exmem_addr != 5'd0) && (exmem_addr == src_addr[gi])) ? exmem_data :
        (memwb_we && (memwb_addr != 5'd0) && (memwb_addr == src_addr[gi])) ? memwb_data :
        src_data[gi];
    end
  endgenerate

  assign sext = {{(DATA_W-16){imm[15]}}, imm};
  assign zext = {{(DATA_W-16){1'b0}}, imm};

  always_comb begin
    dec_d      = '{a: fwd_data[0], b: fwd_data[1], ctrl: 4'b0010, dest: rd_addr, wr: 1'b1, ill: 1'b0};
    unique case (opcode)
      6'h00: begin
        unique case (funct)
          6'h20, 6'h21: dec_d.ctrl = 4'b0010;
          6'h22, 6'h23: dec_d.ctrl = 4'b0110;
          6'h24:        dec_d.ctrl = 4'b0000;
          6'h25:        dec_d.ctrl = 4'b0001;
          6'h26:        dec_d.ctrl = 4'b0100;
          6'h27:        dec_d.ctrl = 4'b1100;
          6'h2A:        dec_d.ctrl = 4'b0111;
          6'h18:        dec_d.ctrl = 4'b0101;
          6'h1A:        dec_d.ctrl = 4'b1011;
          6'h00, 6'h02, 6'h03: begin
            // Shifts operate on rt; shamt travels in b[10:6] of the zero-extended immediate.
            dec_d.ctrl = (funct == 6'h00) ? 4'b1000 : (funct == 6'h02) ? 4'b1001 : 4'b1010;
            dec_d.a    = fwd_data[1];
            dec_d.b    = zext;
          end
          default: begin
            dec_d.wr  = 1'b0;
            dec_d.ill = 1'b1;
          end
        endcase
      end
      6'h08, 6'h09: begin dec_d.b = sext; dec_d.dest = rt_addr; end
      6'h0A: begin dec_d.ctrl = 4'b0111; dec_d.b = sext; dec_d.dest = rt_addr; end
      6'h0C: begin dec_d.ctrl = 4'b0000; dec_d.b = zext; dec_d.dest = rt_addr; end
      6'h0D: begin dec_d.ctrl = 4'b0001; dec_d.b = zext; dec_d.dest = rt_addr; end
      6'h0E: begin dec_d.ctrl = 4'b0100; dec_d.b = zext; dec_d.dest = rt_addr; end
      6'h23: begin dec_d.b = sext; dec_d.dest = rt_addr; end
      6'h2B: begin dec_d.b = sext; dec_d.dest = rt_addr; dec_d.wr = 1'b0; end
      6'h04: begin dec_d.ctrl = 4'b0110; dec_d.dest = rt_addr; dec_d.wr = 1'b0; end
      default: begin
        dec_d.wr  = 1'b0;
        dec_d.ill = 1'b1;
      end
    endcase
    if (dec_d.dest == 5'd0) dec_d.wr = 1'b0;
  end

  assign accept = in_valid && in_ready;

`ifdef ALU_ISSUE_SKID_EN
  entry_t skid_q;
  logic   skid_valid_q;
  logic   in_ready_q;

  // in_ready_q mirrors !skid_valid_q, so it never depends on out_ready combinationally.
  assign in_ready = in_ready_q && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q        <= RESET_ENTRY;
      skid_q       <= RESET_ENTRY;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
        in_ready_q   <= 1'b1;
      end else begin
        if (accept) out_q <= dec_d;
        out_valid_q <= accept;
      end
    end else if (accept) begin
      skid_q       <= dec_d;
      skid_valid_q <= 1'b1;
      in_ready_q   <= 1'b0;
    end
  end
`else
  assign in_ready = !reset && (!out_valid_q || out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= RESET_ENTRY;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_q       <= dec_d;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  assign out_valid     = out_valid_q;
  assign alu_a         = out_q.a;
  assign alu_b         = out_q.b;
  assign alu_control   = out_q.ctrl;
  assign out_dest      = out_q.dest;
  assign out_reg_write = out_q.wr;
  assign illegal       = out_q.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage: decode, forwarding, handshake, flush and reset.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [31:0] rs_data, rt_data;
  logic [15:0] imm;
  logic        flush;
  logic        exmem_we, memwb_we;
  logic [4:0]  exmem_addr, memwb_addr;
  logic [31:0] exmem_data, memwb_data;
  logic        out_valid, out_ready;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_control;
  logic [4:0]  out_dest;
  logic        out_reg_write, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  alu_issue_stage #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .flush(flush),
    .exmem_we(exmem_we), .exmem_addr(exmem_addr), .exmem_data(exmem_data),
    .memwb_we(memwb_we), .memwb_addr(memwb_addr), .memwb_data(memwb_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_control(alu_control), .out_dest(out_dest), .out_reg_write(out_reg_write), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single cycle; caller guarantees in_ready is high.
  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rsd,
                       input logic [31:0] rtd, input logic [15:0] im);
    opcode = op; funct = fn; rs_addr = rs; rt_addr = rt; rd_addr = rd;
    rs_data = rsd; rt_data = rtd; imm = im; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    $display("txn op=%h fn=%h -> valid=%0d ctrl=%b a=%h b=%h dest=%0d we=%0d ill=%0d",
             op, fn, out_valid, alu_control, alu_a, alu_b, out_dest, out_reg_write, illegal);
  endtask

  initial begin
    int sent, recv, cyc, stall_acc, exp_stall_acc;
    logic acc, fire, was_stall;
    logic [31:0] got_a;

    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    opcode = '0; funct = '0; rs_addr = '0; rt_addr = '0; rd_addr = '0;
    rs_data = '0; rt_data = '0; imm = '0;
    exmem_we = 1'b0; exmem_addr = '0; exmem_data = '0;
    memwb_we = 1'b0; memwb_addr = '0; memwb_data = '0;
    tick(); tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_a", alu_a, 32'd0);
    check("rst_b", alu_b, 32'd0);
    check("rst_ctrl", {28'd0, alu_control}, 32'h2);
    check("rst_dest", {27'd0, out_dest}, 32'd0);
    check("rst_we", {31'd0, out_reg_write}, 32'd0);
    check("rst_ill", {31'd0, illegal}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0);
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_ctrl", {28'd0, alu_control}, 32'h2);
    check("add_a", alu_a, 32'd5);
    check("add_b", alu_b, 32'd7);
    check("add_dest", {27'd0, out_dest}, 32'd3);
    check("add_we", {31'd0, out_reg_write}, 32'd1);

    drive(6'h08, 6'h00, 5'd1, 5'd4, 5'd0, 32'd10, 32'd0, 16'hFFFF);
    check("addi_b", alu_b, 32'hFFFF_FFFF);
    check("addi_dest", {27'd0, out_dest}, 32'd4);
    check("addi_we", {31'd0, out_reg_write}, 32'd1);

    drive(6'h0D, 6'h00, 5'd1, 5'd4, 5'd0, 32'd10, 32'd0, 16'hFFFF);
    check("ori_b", alu_b, 32'h0000_FFFF);
    check("ori_ctrl", {28'd0, alu_control}, 32'h1);

    drive(6'h00, 6'h03, 5'd1, 5'd2, 5'd6, 32'h1234_5678, 32'h8000_0000, 16'h0100);
    check("sra_a", alu_a, 32'h8000_0000);
    check("sra_shamt", {27'd0, alu_b[10:6]}, 32'd4);
    check("sra_ctrl", {28'd0, alu_control}, 32'hA);

    exmem_we = 1'b1; exmem_addr = 5'd2; exmem_data = 32'hAAAA_0001;
    memwb_we = 1'b1; memwb_addr = 5'd2; memwb_data = 32'hBBBB_0002;
    drive(6'h00, 6'h20, 5'd2, 5'd7, 5'd3, 32'd1, 32'd9, 16'h0);
    check("fwd_exmem_wins", alu_a, 32'hAAAA_0001);
    check("fwd_no_rt", alu_b, 32'd9);

    memwb_addr = 5'd7;
    drive(6'h00, 6'h20, 5'd2, 5'd7, 5'd3, 32'd1, 32'd9, 16'h0);
    check("fwd_memwb_rt", alu_b, 32'hBBBB_0002);

    exmem_addr = 5'd0; memwb_addr = 5'd0;
    drive(6'h00, 6'h20, 5'd0, 5'd7, 5'd3, 32'h0000_0055, 32'd9, 16'h0);
    check("fwd_r0_blocked", alu_a, 32'h0000_0055);
    exmem_we = 1'b0; memwb_we = 1'b0;

    drive(6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'h0);
    check("ill_flag", {31'd0, illegal}, 32'd1);
    check("ill_we", {31'd0, out_reg_write}, 32'd0);
    check("ill_ctrl", {28'd0, alu_control}, 32'h2);
    check("ill_valid", {31'd0, out_valid}, 32'd1);

    drive(6'h00, 6'h22, 5'd1, 5'd2, 5'd0, 32'd1, 32'd2, 16'h0);
    check("sub_ctrl", {28'd0, alu_control}, 32'h6);
    check("rd0_we", {31'd0, out_reg_write}, 32'd0);

    drive(6'h2B, 6'h00, 5'd1, 5'd2, 5'd0, 32'd1, 32'd2, 16'h8000);
    check("sw_b", alu_b, 32'hFFFF_8000);
    check("sw_we", {31'd0, out_reg_write}, 32'd0);

    // Flush with a held entry and a simultaneous input: both must vanish.
    drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0);
    out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1;
    tick();
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("flush_drop", {31'd0, out_valid}, 32'd0);
    $display("txn flush -> valid=%0d", out_valid);

    // Reset during a stall discards the held entry.
    drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'h0000_0042, 32'd7, 16'h0);
    out_ready = 1'b0;
    tick();
    check("stall_keep", alu_a, 32'h0000_0042);
    reset = 1'b1;
    tick();
    check("rst_stall_valid", {31'd0, out_valid}, 32'd0);
    check("rst_stall_a", alu_a, 32'd0);
    reset = 1'b0; out_ready = 1'b1;
    tick();
    $display("txn reset_mid_stall -> valid=%0d", out_valid);

    // Stream of six addi with a three-cycle output stall.
    sent = 0; recv = 0; cyc = 0; stall_acc = 0;
`ifdef ALU_ISSUE_SKID_EN
    exp_stall_acc = 1;
`else
    exp_stall_acc = 0;
`endif
    opcode = 6'h08; funct = 6'h00; rs_addr = 5'd1; rt_addr = 5'd5; imm = 16'h0;
    while (recv < 6 && cyc < 40) begin
      out_ready = !(cyc >= 2 && cyc <= 4);
      in_valid  = (sent < 6);
      rs_data   = 32'd100 + sent;
      #1;
      acc = in_valid && in_ready;
      fire = out_valid && out_ready;
      was_stall = out_valid && !out_ready;
      got_a = alu_a;
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        if (!out_ready) stall_acc++;
      end
      if (fire) begin
        check("stream_a", got_a, 32'd100 + recv);
        $display("txn stream item %0d a=%0d", recv, got_a);
        recv++;
      end
      if (was_stall) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_hold", alu_a, got_a);
      end
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_count", recv, 32'd6);
    check("stream_cycles", cyc, 32'd10);
    check("stall_accepts", stall_acc, exp_stall_acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
